// File: rtl/dcache_pkg.sv
// Shared widths, state encoding and address-field helpers for the direct-mapped
// write-through data cache.
package dcache_pkg;

    localparam int ADDR_WIDTH     = 10;
    localparam int DATA_WIDTH     = 32;
    localparam int LINE_WIDTH     = 128;
    localparam int NUM_LINES      = 32;
    localparam int INDEX_W        = $clog2(NUM_LINES);
    localparam int TAG_W          = ADDR_WIDTH - 2 - INDEX_W;
    localparam int CNT_W          = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_e;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [INDEX_W-1:0]    index_t;
    typedef logic [TAG_W-1:0]      tag_t;

    function automatic index_t addr_index(input addr_t a);
        return a[INDEX_W+1:2];
    endfunction

    function automatic tag_t addr_tag(input addr_t a);
        return a[ADDR_WIDTH-1:INDEX_W+2];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Core load/store port plus memory line-refill / word-write port of the cache.
interface dcache_if;
    import dcache_pkg::*;

    logic                  cpu_read;
    logic                  cpu_write;
    addr_t                 cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  stall;
    logic                  mem_read;
    logic                  mem_write;
    addr_t                 mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        output cpu_rdata, stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        input  cpu_rdata, stall, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_array.sv
// Data/tag/valid storage: combinational lookup, synchronous line fill and word write.
// Only the valid bits are reset; data and tags are qualified by them.
module dcache_array
    import dcache_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  index_t                index_i,
    output logic [LINE_WIDTH-1:0] rd_line_o,
    output tag_t                  rd_tag_o,
    output logic                  rd_valid_o,
    input  logic                  fill_en_i,
    input  tag_t                  fill_tag_i,
    input  logic [LINE_WIDTH-1:0] fill_line_i,
    input  logic                  wr_en_i,
    input  logic [1:0]            wr_offset_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i
);

    logic [LINE_WIDTH-1:0] data_q [NUM_LINES];
    tag_t                  tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0]  valid_q;
    logic [6:0]            wr_bit;

    assign wr_bit     = {wr_offset_i, 5'd0};
    assign rd_line_o  = data_q[index_i];
    assign rd_tag_o   = tag_q[index_i];
    assign rd_valid_o = valid_q[index_i];

    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            data_q[index_i] <= fill_line_i;
            tag_q[index_i]  <= fill_tag_i;
        end else if (wr_en_i) begin
            data_q[index_i][wr_bit +: DATA_WIDTH] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (fill_en_i) begin
            valid_q[index_i] <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-through, no-write-allocate cache controller: serves read
// hits in the same cycle, stalls the core for line refills and write-throughs.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    dcache_if.slave          bus,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      hit_q, hit_d;
    logic [CNT_W-1:0]      miss_q, miss_d;

    index_t                index;
    tag_t                  tag;
    logic [LINE_WIDTH-1:0] line;
    tag_t                  line_tag;
    logic                  line_valid;
    logic                  hit;
    logic [6:0]            rd_bit;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  fill_en;
    logic                  wr_en;
    logic                  stall;
    logic                  mem_read;
    logic                  mem_write;
    addr_t                 mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    assign index   = addr_index(bus.cpu_addr);
    assign tag     = addr_tag(bus.cpu_addr);
    assign hit     = line_valid && (line_tag == tag);
    assign rd_bit  = {bus.cpu_addr[1:0], 5'd0};
    assign rd_word = line[rd_bit +: DATA_WIDTH];

    dcache_array u_array (
        .clk         (clk),
        .reset       (reset),
        .index_i     (index),
        .rd_line_o   (line),
        .rd_tag_o    (line_tag),
        .rd_valid_o  (line_valid),
        .fill_en_i   (fill_en),
        .fill_tag_i  (tag),
        .fill_line_i (bus.mem_rdata),
        .wr_en_i     (wr_en),
        .wr_offset_i (bus.cpu_addr[1:0]),
        .wr_data_i   (bus.cpu_wdata)
    );

    // Everything is gated by reset so an in-flight request drops immediately
    // and no refill or store can land in the array during reset.
    always_comb begin
        state_d   = state_q;
        hit_d     = hit_q;
        miss_d    = miss_q;
        fill_en   = 1'b0;
        wr_en     = 1'b0;
        stall     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_rdata = '0;
        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.cpu_write) begin
                        stall   = 1'b1;
                        wr_en   = hit;
                        state_d = WR_THRU;
                    end else if (bus.cpu_read) begin
                        if (hit) begin
                            cpu_rdata = rd_word;
                            hit_d     = sat_inc(hit_q);
                        end else begin
                            stall   = 1'b1;
                            miss_d  = sat_inc(miss_q);
                            state_d = RD_MISS;
                        end
                    end
                end
                RD_MISS: begin
                    stall    = 1'b1;
                    mem_read = 1'b1;
                    mem_addr = bus.cpu_addr;
                    if (bus.mem_ready) begin
                        fill_en = 1'b1;
                        state_d = IDLE;
                    end
                end
                WR_THRU: begin
                    stall     = 1'b1;
                    mem_write = 1'b1;
                    mem_addr  = bus.cpu_addr;
                    mem_wdata = bus.cpu_wdata;
                    if (bus.mem_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    assign bus.stall     = stall;
    assign bus.mem_read  = mem_read;
    assign bus.mem_write = mem_write;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.cpu_rdata = cpu_rdata;
    assign hit_count     = hit_q;
    assign miss_count    = miss_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a line-level
// cache model and a word-addressed memory with programmable ready latency.
module tb_dcache_controller;
    import dcache_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic [15:0] hit_count, miss_count;

    always #5 clk = ~clk;

    dcache_if bus ();

    dcache_controller dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_model [1024];

    bit          ref_valid [32];
    int          ref_la    [32];
    logic [31:0] ref_data  [32][4];
    int          ref_hits;
    int          ref_misses;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
    endtask

    task automatic model_access(input bit wr, input int addr, input logic [31:0] wdata,
                                input int lat, output logic [31:0] exp_data,
                                output int exp_stalls);
        int la  = addr / 4;
        int idx = la % 32;
        int off = addr % 4;
        bit h   = ref_valid[idx] && (ref_la[idx] == la);
        exp_data = '0;
        if (wr) begin
            exp_stalls = lat + 2;
            if (h) ref_data[idx][off] = wdata;
        end else if (h) begin
            exp_stalls = 0;
            exp_data   = ref_data[idx][off];
            if (ref_hits < 65535) ref_hits++;
        end else begin
            if (ref_misses < 65535) ref_misses++;
            for (int w = 0; w < 4; w++) ref_data[idx][w] = mem_model[la*4 + w];
            ref_valid[idx] = 1'b1;
            ref_la[idx]    = la;
            if (ref_hits < 65535) ref_hits++;
            exp_stalls = lat + 2;
            exp_data   = ref_data[idx][off];
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the access has retired.
    task automatic access(input bit wr, input bit both, input logic [9:0] addr,
                          input logic [31:0] wdata, input int lat,
                          output int stalls, output logic [31:0] rdata,
                          output bit proto_ok, output bit timed_out);
        int  reqc  = 0;
        bit  wdone = 0;
        bit  done  = 0;
        int  la    = int'(addr) / 4;
        stalls    = 0;
        rdata     = '0;
        proto_ok  = 1'b1;
        timed_out = 1'b0;
        bus.cpu_read  = !wr || both;
        bus.cpu_write = wr;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            #1;
            if (!bus.stall) begin
                if (!wr) rdata = bus.cpu_rdata;
                if (bus.mem_read || bus.mem_write) proto_ok = 1'b0;
                done = 1'b1;
            end else begin
                stalls++;
                if (bus.mem_read || bus.mem_write) begin
                    if (bus.mem_addr !== addr) proto_ok = 1'b0;
                    if (bus.mem_read !== !wr || bus.mem_write !== wr) proto_ok = 1'b0;
                    if (wr && bus.mem_wdata !== wdata) proto_ok = 1'b0;
                    if (!wr && bus.mem_wdata !== 32'h0) proto_ok = 1'b0;
                    reqc++;
                    if (reqc == lat + 1) begin
                        bus.mem_ready = 1'b1;
                        bus.mem_rdata = {mem_model[la*4+3], mem_model[la*4+2],
                                         mem_model[la*4+1], mem_model[la*4]};
                        if (wr) begin
                            mem_model[addr] = wdata;
                            wdone = 1'b1;
                        end
                    end
                end else if (cyc > 0) begin
                    proto_ok = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            bus.mem_ready = 1'b0;
            bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            if (wdone) begin
                bus.cpu_write = 1'b0;
                bus.cpu_read  = 1'b0;
            end
        end
        if (!done) timed_out = 1'b1;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", bus.stall); end
        total++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%0b%0b exp=00", bus.mem_read, bus.mem_write); end
        total++; if (bus.mem_addr !== 10'h0 || bus.mem_wdata !== 32'h0 || bus.cpu_rdata !== 32'h0) begin bad++; $display("FAIL reset_buses addr=%h wdata=%h rdata=%h exp=0", bus.mem_addr, bus.mem_wdata, bus.cpu_rdata); end
        total++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin bad++; $display("FAIL reset_counters hit=%0d miss=%0d exp=0", hit_count, miss_count); end
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // One access compared against the model: stall cycles, read data, bus protocol, counters.
    task automatic checked_access(input string name, input bit wr, input bit both,
                                  input logic [9:0] addr, input logic [31:0] wdata, input int lat);
        int          st, exp_st;
        logic [31:0] rd, exp_rd;
        bit          ok, to;
        model_access(wr, int'(addr), wdata, lat, exp_rd, exp_st);
        access(wr, both, addr, wdata, lat, st, rd, ok, to);
        total++; if (to) begin bad++; $display("FAIL %s_timeout addr=%h got=no_completion exp=completion", name, addr); end
        total++; if (st !== exp_st) begin bad++; $display("FAIL %s_stalls addr=%h got=%0d exp=%0d", name, addr, st, exp_st); end
        if (!wr) begin
            total++; if (rd !== exp_rd) begin bad++; $display("FAIL %s_rdata addr=%h got=%h exp=%h", name, addr, rd, exp_rd); end
        end
        total++; if (!ok) begin bad++; $display("FAIL %s_protocol addr=%h got=bad_mem_signals exp=clean", name, addr); end
        total++; if (hit_count !== 16'(ref_hits) || miss_count !== 16'(ref_misses)) begin
            bad++; $display("FAIL %s_counters hit=%0d miss=%0d exp_hit=%0d exp_miss=%0d", name, hit_count, miss_count, ref_hits, ref_misses);
        end
    endtask

    task automatic test_read_miss_then_hit();
        checked_access("miss_0x004", 0, 0, 10'h004, 32'h0, 4);
        total++; if (hit_count !== 16'd1 || miss_count !== 16'd1) begin bad++; $display("FAIL plan_counters hit=%0d miss=%0d exp=1/1", hit_count, miss_count); end
        checked_access("hit_0x006", 0, 0, 10'h006, 32'h0, 4);
        total++; if (hit_count !== 16'd2) begin bad++; $display("FAIL plan_hit2 got=%0d exp=2", hit_count); end
    endtask

    task automatic test_write_hit();
        checked_access("wr_hit_0x005", 1, 0, 10'h005, 32'h1234, 4);
        checked_access("rd_after_wr_0x005", 0, 0, 10'h005, 32'h0, 4);
    endtask

    task automatic test_write_miss();
        checked_access("wr_miss_0x3f0", 1, 0, 10'h3F0, 32'h55, 4);
        checked_access("rd_0x3f0", 0, 0, 10'h3F0, 32'h0, 4);
    endtask

    task automatic test_conflict();
        checked_access("conf_a", 0, 0, 10'h004, 32'h0, 4);
        checked_access("conf_b", 0, 0, 10'h084, 32'h0, 4);
        checked_access("conf_c", 0, 0, 10'h004, 32'h0, 4);
    endtask

    task automatic test_ready_in_idle();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = {4{32'hDEADBEEF}};
        #1;
        total++; if (bus.stall !== 1'b0 || bus.mem_read !== 1'b0) begin bad++; $display("FAIL idle_ready_outputs stall=%0b mem_read=%0b exp=0/0", bus.stall, bus.mem_read); end
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        checked_access("idle_ready_hit", 0, 0, 10'h006, 32'h0, 4);
    endtask

    task automatic test_reset_mid_miss();
        bus.cpu_read = 1'b1;
        bus.cpu_addr = 10'h200;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.mem_read !== 1'b1) begin bad++; $display("FAIL midrst_in_miss mem_read=%0b exp=1", bus.mem_read); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.cpu_read = 1'b0;
        #1;
        total++; if (bus.mem_read !== 1'b0 || bus.stall !== 1'b0) begin bad++; $display("FAIL midrst_idle mem_read=%0b stall=%0b exp=0/0", bus.mem_read, bus.stall); end
        total++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin bad++; $display("FAIL midrst_counters hit=%0d miss=%0d exp=0", hit_count, miss_count); end
        model_reset();
        @(posedge clk);
        #1;
        checked_access("midrst_reread", 0, 0, 10'h004, 32'h0, 4);
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            logic [9:0] a;
            bit wr   = ($urandom_range(0, 99) < 30);
            bit both = wr && ($urandom_range(0, 3) == 0);
            int lat  = int'($urandom_range(1, 5));
            a = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            checked_access(wr ? "rnd_wr" : "rnd_rd", wr, both, a, $urandom, lat);
        end
    endtask

    task automatic test_saturation();
        int need;
        checked_access("sat_prime", 0, 0, 10'h010, 32'h0, 2);
        need = 65535 - ref_hits;
        bus.cpu_read = 1'b1;
        bus.cpu_addr = 10'h010;
        repeat (need) @(posedge clk);
        #1;
        total++; if (hit_count !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got=%h exp=ffff", hit_count); end
        repeat (20) @(posedge clk);
        #1;
        bus.cpu_read = 1'b0;
        total++; if (hit_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", hit_count); end
        total++; if (miss_count !== 16'(ref_misses)) begin bad++; $display("FAIL sat_miss got=%0d exp=%0d", miss_count, ref_misses); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = $urandom;
        mem_model[4] = 32'hA;
        mem_model[5] = 32'hB;
        mem_model[6] = 32'hC;
        mem_model[7] = 32'hD;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        reset         = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_read_miss_then_hit();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_ready_in_idle();
        test_reset_mid_miss();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
